answer_arbiter: RTL and testbench
=================================

// Module: answer_arbiter
// PURPOSE
//  Shares the single answer-judge datapath between two players during the INPUT phase of a round.
//  Grants one submitter at a time and launches the judge. A correct answer ends the round.
//  A wrong answer locks that player out for a timed penalty while the other player may still answer.
//  Sits between the player submit buttons and the judge unit; results feed the game CONTROL FSM.
// PARAMETERS
//  LOCK_CYCLES   50_000_000  penalty length in CLK cycles (1 s at 50 MHz)
//  CNT_W         26          width of lockout/timeout counters; must hold LOCK_CYCLES-1
//  TIMEOUT_CYCLES 25_000_000 judge response limit (used only with JUDGE_TIMEOUT_EN)
// PORTS
//  CLK           in   1  system clock
//  RST           in   1  synchronous reset, active-high
//  ROUND_EN      in   1  high while CONTROL is in INPUT; low aborts the round
//  REQ           in   2  submit buttons, level; bit0 = player0, bit1 = player1
//  JUDG_VALID    in   1  one-cycle pulse: judge verdict available
//  JUDG_OK       in   1  verdict, sampled with JUDG_VALID (1 = correct)
//  GNT           out  2  one-hot owner of judge, 00 = none
//  JUDGE_START   out  1  one-cycle pulse launching judge for GNT owner
//  LOCKED        out  2  per-player lockout active
//  RESULT        out  2  01 = player0 correct, 10 = player1 correct, held until round end
//  RESULT_VALID  out  1  one-cycle pulse when RESULT is set
//  BOTH_LOCKED   out  1  both LOCKED bits high
// BEHAVIOUR
//  - Reset is synchronous and active-high. All outputs reset to 0. FSM resets to IDLE. Counters reset to 0.
//    The round-robin pointer resets to player0.
//  - REQ is rising-edge detected internally with a registered previous value. A held button fires once.
//  - A player is eligible when its edge is seen, LOCKED[p] = 0 and the FSM is in WAIT.
//    Edges that arrive at any other time are dropped, not queued.
//  - FSM states:
//    IDLE: outputs 0. Go to WAIT when ROUND_EN = 1.
//    WAIT: an eligible edge at cycle n → GRANT at n+1, with GNT set and JUDGE_START = 1 for that cycle only.
//      If both players are eligible in the same cycle, the pointer's player wins.
//      The pointer toggles after every grant.
//    GRANT: hold GNT and wait for JUDG_VALID.
//      JUDG_OK = 1 → DONE. On the next cycle RESULT = GNT, RESULT_VALID pulses and GNT clears.
//      JUDG_OK = 0 → WAIT. On the next cycle LOCKED[p] = 1, the counter loads 0 and GNT clears.
//    DONE: hold RESULT and ignore all REQ edges. Go to IDLE when ROUND_EN = 0, which clears RESULT.
//  - Lockout: each player has its own counter that increments while LOCKED[p] = 1.
//    At count LOCK_CYCLES-1, LOCKED[p] clears on the next edge and the player is eligible from the cycle after.
//    An REQ edge in the same cycle as the expiry is ignored.
//  - The other player's lockout keeps counting while a grant is in progress.
//  - JUDG_VALID outside GRANT is ignored.
//  - ROUND_EN falling in any state → IDLE on the next cycle. This clears GNT, LOCKED, counters and RESULT.
//    The pointer is kept.
//  - RST mid-operation has the same effect as ROUND_EN falling, and also resets the pointer.
//  - The counters never wrap; they saturate until reloaded.
// CONFIGURATION
//  - JUDGE_TIMEOUT_EN defined: a third counter runs in GRANT.
//    If JUDG_VALID has not arrived after TIMEOUT_CYCLES cycles, the grant is treated as JUDG_OK = 0
//    (lockout, return to WAIT). A late JUDG_VALID is then ignored.
//  - Undefined: GRANT waits indefinitely; only ROUND_EN low or RST exits.
// TESTING (LOCK_CYCLES=8, TIMEOUT_CYCLES=5 for sim)
//  1. RST, ROUND_EN=1, REQ=01 edge at cycle 3 → GNT=01 and JUDGE_START pulse at cycle 4.
//     JUDG_VALID with OK=1 → RESULT=01 plus RESULT_VALID pulse.
//  2. REQ=11 rising in the same cycle after reset → GNT=01.
//     Wrong verdict, then the next simultaneous edge → GNT=10 (pointer toggled).
//  3. Player0 judged wrong → LOCKED=01 for exactly 8 cycles.
//     A REQ0 edge during the lock is ignored. An edge 1 cycle after LOCKED clears → grant.
//  4. Both players wrong back-to-back → BOTH_LOCKED=1.
//     Player0 unlocks first. ROUND_EN low mid-lock → LOCKED=00 and IDLE next cycle.
//  5. REQ0 held high for 100 cycles → exactly one JUDGE_START.
//     ROUND_EN dropped in GRANT → GNT=00 next cycle, and a stray JUDG_VALID is ignored.
//  6. With JUDGE_TIMEOUT_EN: no JUDG_VALID for 5 cycles in GRANT → LOCKED[p]=1, back to WAIT.
//     A later JUDG_VALID is ignored.

Source files
------------

// File: rtl/answer_arbiter_if.sv
// Handshake bundle between the player buttons, the judge unit and answer_arbiter.
// The slave modport is the arbiter side, the master modport is the driver side.
interface answer_arbiter_if;
  logic       ROUND_EN;
  logic [1:0] REQ;
  logic       JUDG_VALID;
  logic       JUDG_OK;
  logic [1:0] GNT;
  logic       JUDGE_START;
  logic [1:0] LOCKED;
  logic [1:0] RESULT;
  logic       RESULT_VALID;
  logic       BOTH_LOCKED;

  modport slave (
    input  ROUND_EN, REQ, JUDG_VALID, JUDG_OK,
    output GNT, JUDGE_START, LOCKED,
    output RESULT, RESULT_VALID, BOTH_LOCKED
  );

  modport master (
    output ROUND_EN, REQ, JUDG_VALID, JUDG_OK,
    input  GNT, JUDGE_START, LOCKED,
    input  RESULT, RESULT_VALID, BOTH_LOCKED
  );
endinterface

// File: rtl/answer_arbiter.sv
// Two-player answer arbiter: round-robin grant of the judge, wrong-answer lockout.
// Optional JUDGE_TIMEOUT_EN: a silent judge is treated as a wrong verdict.
module answer_arbiter #(
  parameter int LOCK_CYCLES    = 50_000_000,
  parameter int CNT_W          = 26,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input logic CLK,
  input logic RST,
  answer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] LOCK_MAX =
    CNT_W'(LOCK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       req_prev_q;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       locked_q, locked_d;
  logic [1:0]       result_q, result_d;
  logic             start_q, start_d;
  logic             rvalid_q, rvalid_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       req_edge;
  logic [1:0]       elig;
  logic [1:0]       pick;
  logic             tmo_exp;

  assign req_edge = bus.REQ & ~req_prev_q;
  assign elig     = req_edge & ~locked_q;

`ifdef JUDGE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_MAX =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_q, tmo_d;

  assign tmo_exp = (state_q == GRANT) &&
                   (tmo_q == TMO_MAX);
  assign tmo_d   = (state_q == GRANT && !tmo_exp) ?
                   tmo_q + 1'b1 : '0;

  always_ff @(posedge CLK) begin
    if (RST) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_exp = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    locked_d = locked_q;
    result_d = result_q;
    ptr_d    = ptr_q;
    start_d  = 1'b0;
    rvalid_d = 1'b0;
    cnt_d[0] = cnt_q[0];
    cnt_d[1] = cnt_q[1];

    pick = elig;
    if (elig == 2'b11) pick = ptr_q ? 2'b10 : 2'b01;

    // Lockout runs in every state, including another player's grant
    for (int p = 0; p < 2; p++) begin
      if (locked_q[p]) begin
        if (cnt_q[p] == LOCK_MAX) locked_d[p] = 1'b0;
        else cnt_d[p] = cnt_q[p] + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.ROUND_EN) state_d = WAIT;
      end
      WAIT: begin
        if (elig != 2'b00) begin
          state_d = GRANT;
          gnt_d   = pick;
          start_d = 1'b1;
          ptr_d   = ~ptr_q;
        end
      end
      GRANT: begin
        if (bus.JUDG_VALID && bus.JUDG_OK) begin
          state_d  = DONE;
          result_d = gnt_q;
          rvalid_d = 1'b1;
          gnt_d    = 2'b00;
        end else if (bus.JUDG_VALID || tmo_exp) begin
          state_d = WAIT;
          gnt_d   = 2'b00;
          for (int p = 0; p < 2; p++) begin
            if (gnt_q[p]) begin
              locked_d[p] = 1'b1;
              cnt_d[p]    = '0;
            end
          end
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    if (!bus.ROUND_EN) begin
      state_d  = IDLE;
      gnt_d    = 2'b00;
      locked_d = 2'b00;
      result_d = 2'b00;
      start_d  = 1'b0;
      rvalid_d = 1'b0;
      cnt_d[0] = '0;
      cnt_d[1] = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      req_prev_q <= 2'b00;
      gnt_q      <= 2'b00;
      locked_q   <= 2'b00;
      result_q   <= 2'b00;
      start_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      ptr_q      <= 1'b0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= bus.REQ;
      gnt_q      <= gnt_d;
      locked_q   <= locked_d;
      result_q   <= result_d;
      start_q    <= start_d;
      rvalid_q   <= rvalid_d;
      ptr_q      <= ptr_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
    end
  end

  assign bus.GNT          = gnt_q;
  assign bus.JUDGE_START  = start_q;
  assign bus.LOCKED       = locked_q;
  assign bus.RESULT       = result_q;
  assign bus.RESULT_VALID = rvalid_q;
  assign bus.BOTH_LOCKED  = &locked_q;

endmodule

// File: tb/tb_answer_arbiter.sv
// Directed bench for answer_arbiter with LOCK_CYCLES=8, TIMEOUT_CYCLES=5.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_answer_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   starts;

  answer_arbiter_if bus ();

  answer_arbiter #(
    .LOCK_CYCLES   (8),
    .CNT_W         (26),
    .TIMEOUT_CYCLES(5)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic verdict(input logic ok);
    bus.JUDG_VALID = 1'b1;
    bus.JUDG_OK    = ok;
    tick();
    bus.JUDG_VALID = 1'b0;
    bus.JUDG_OK    = 1'b0;
  endtask

  task automatic end_round();
    bus.ROUND_EN = 1'b0;
    bus.REQ      = 2'b00;
    tick();
  endtask

  task automatic start_round();
    bus.ROUND_EN = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ROUND_EN   = 1'b0;
    bus.REQ        = 2'b00;
    bus.JUDG_VALID = 1'b0;
    bus.JUDG_OK    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_gnt", 32'(bus.GNT), 0);
    chk("rst_locked", 32'(bus.LOCKED), 0);
    chk("rst_result", 32'(bus.RESULT), 0);
    chk("rst_rvalid", 32'(bus.RESULT_VALID), 0);
    chk("rst_start", 32'(bus.JUDGE_START), 0);
    chk("rst_both", 32'(bus.BOTH_LOCKED), 0);

    // 1: single grant, correct verdict, DONE ignores edges
    start_round();
    bus.REQ = 2'b01;
    tick();
    chk("t1_gnt", 32'(bus.GNT), 32'h1);
    chk("t1_start", 32'(bus.JUDGE_START), 1);
    tick();
    chk("t1_start_off", 32'(bus.JUDGE_START), 0);
    chk("t1_gnt_hold", 32'(bus.GNT), 32'h1);
    verdict(1'b1);
    chk("t1_result", 32'(bus.RESULT), 32'h1);
    chk("t1_rvalid", 32'(bus.RESULT_VALID), 1);
    chk("t1_gnt_clr", 32'(bus.GNT), 0);
    bus.REQ = 2'b00;
    tick();
    chk("t1_rvalid_off", 32'(bus.RESULT_VALID), 0);
    bus.REQ = 2'b10;
    tick();
    tick();
    chk("t1_done_gnt", 32'(bus.GNT), 0);
    chk("t1_done_start", 32'(bus.JUDGE_START), 0);
    chk("t1_done_result", 32'(bus.RESULT), 32'h1);
    end_round();
    chk("t1_idle_result", 32'(bus.RESULT), 0);

    // 2: simultaneous edges after reset, pointer toggles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_round();
    bus.REQ = 2'b11;
    tick();
    chk("t2_tie_p0", 32'(bus.GNT), 32'h1);
    verdict(1'b0);
    chk("t2_lock_p0", 32'(bus.LOCKED), 32'h1);
    chk("t2_gnt_clr", 32'(bus.GNT), 0);
    bus.REQ = 2'b00;
    tick();
    bus.REQ = 2'b11;
    tick();
    chk("t2_second_p1", 32'(bus.GNT), 32'h2);
    verdict(1'b1);
    chk("t2_result_p1", 32'(bus.RESULT), 32'h2);
    end_round();
    start_round();
    bus.REQ = 2'b11;
    tick();
    chk("t2_tie_ptr0", 32'(bus.GNT), 32'h1);
    verdict(1'b1);
    end_round();
    start_round();
    bus.REQ = 2'b11;
    tick();
    chk("t2_tie_ptr_kept", 32'(bus.GNT), 32'h2);
    verdict(1'b1);
    end_round();

    // 3: lockout lasts exactly 8 cycles, edge during lock dropped
    start_round();
    bus.REQ = 2'b01;
    tick();
    chk("t3_gnt", 32'(bus.GNT), 32'h1);
    bus.REQ = 2'b00;
    verdict(1'b0);
    chk("t3_lock_s1", 32'(bus.LOCKED), 32'h1);
    for (int i = 2; i <= 8; i++) begin
      if (i == 3) bus.REQ = 2'b01;
      if (i == 5) bus.REQ = 2'b00;
      tick();
      chk($sformatf("t3_lock_s%0d", i), 32'(bus.LOCKED), 32'h1);
      chk($sformatf("t3_nogrant_s%0d", i), 32'(bus.GNT), 0);
    end
    tick();
    chk("t3_unlock", 32'(bus.LOCKED), 0);
    bus.REQ = 2'b01;
    tick();
    chk("t3_regrant", 32'(bus.GNT), 32'h1);
    chk("t3_regrant_start", 32'(bus.JUDGE_START), 1);
    verdict(1'b1);
    end_round();

    // 4: both locked, p0 unlocks first, expiry-cycle edge dropped
    start_round();
    bus.REQ = 2'b01;
    tick();
    bus.REQ = 2'b00;
    verdict(1'b0);
    bus.REQ = 2'b10;
    tick();
    chk("t4_gnt_p1", 32'(bus.GNT), 32'h2);
    verdict(1'b0);
    chk("t4_locked", 32'(bus.LOCKED), 32'h3);
    chk("t4_both", 32'(bus.BOTH_LOCKED), 1);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_still_both", 32'(bus.LOCKED), 32'h3);
    bus.REQ = 2'b11;
    tick();
    chk("t4_p0_first", 32'(bus.LOCKED), 32'h2);
    chk("t4_both_off", 32'(bus.BOTH_LOCKED), 0);
    chk("t4_expiry_edge", 32'(bus.GNT), 0);
    bus.ROUND_EN = 1'b0;
    tick();
    chk("t4_abort_locked", 32'(bus.LOCKED), 0);
    bus.REQ = 2'b00;
    tick();
    bus.REQ = 2'b01;
    tick();
    chk("t4_idle_nogrant", 32'(bus.GNT), 0);
    end_round();

    // 5: held button fires once; abort during GRANT
    start_round();
    starts = 0;
    bus.REQ = 2'b01;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.JUDGE_START === 1'b1) starts++;
    end
    chk("t5_one_start", 32'(starts), 1);
`ifndef JUDGE_TIMEOUT_EN
    chk("t5_still_gnt", 32'(bus.GNT), 32'h1);
`endif
    end_round();
    start_round();
    bus.REQ = 2'b10;
    tick();
    chk("t5_gnt_p1", 32'(bus.GNT), 32'h2);
    bus.ROUND_EN = 1'b0;
    tick();
    chk("t5_abort_gnt", 32'(bus.GNT), 0);
    verdict(1'b1);
    chk("t5_stray_result", 32'(bus.RESULT), 0);
    chk("t5_stray_rvalid", 32'(bus.RESULT_VALID), 0);
    end_round();

`ifdef JUDGE_TIMEOUT_EN
    // 6: silent judge times out after 5 GRANT cycles
    start_round();
    bus.REQ = 2'b01;
    tick();
    chk("t6_gnt", 32'(bus.GNT), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t6_hold_%0d", i), 32'(bus.GNT), 32'h1);
    end
    tick();
    chk("t6_tmo_gnt", 32'(bus.GNT), 0);
    chk("t6_tmo_lock", 32'(bus.LOCKED), 32'h1);
    verdict(1'b1);
    chk("t6_late_result", 32'(bus.RESULT), 0);
    chk("t6_late_rvalid", 32'(bus.RESULT_VALID), 0);
    end_round();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
